// File: rtl/sc_regcounter_pkg.sv
// rtl/sc_regcounter_pkg.sv - shared constants and width helpers for the multi-channel counter bank
package sc_regcounter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel-select width: never narrower than one bit, even for a single channel.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/sc_regcounter_multich_if.sv
// rtl/sc_regcounter_multich_if.sv - control/data bundle between game logic and the counter bank
interface sc_regcounter_multich_if
    import sc_regcounter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CHANNELS  = 2
);
    localparam int SELW = sel_width(CHANNELS);

    logic                          SC_RegGENERAL_clear_InHigh;
    logic                          SC_RegGENERAL_load_InHigh;
    logic [SELW-1:0]               SC_RegGENERAL_chSel_InBUS;
    logic [DATAWIDTH-1:0]          SC_RegGENERAL_loadData_InBUS;
    logic [CHANNELS-1:0]           SC_RegGENERAL_en_InBUS;
    logic [CHANNELS-1:0]           SC_RegGENERAL_dir_InBUS;
    logic                          SC_RegGENERAL_sat_InHigh;
    logic [CHANNELS*DATAWIDTH-1:0] SC_RegGENERAL_data_OutBUS;
    logic [CHANNELS-1:0]           SC_RegGENERAL_tc_OutBUS;

    modport master (
        output SC_RegGENERAL_clear_InHigh,
        output SC_RegGENERAL_load_InHigh,
        output SC_RegGENERAL_chSel_InBUS,
        output SC_RegGENERAL_loadData_InBUS,
        output SC_RegGENERAL_en_InBUS,
        output SC_RegGENERAL_dir_InBUS,
        output SC_RegGENERAL_sat_InHigh,
        input  SC_RegGENERAL_data_OutBUS,
        input  SC_RegGENERAL_tc_OutBUS
    );

    modport slave (
        input  SC_RegGENERAL_clear_InHigh,
        input  SC_RegGENERAL_load_InHigh,
        input  SC_RegGENERAL_chSel_InBUS,
        input  SC_RegGENERAL_loadData_InBUS,
        input  SC_RegGENERAL_en_InBUS,
        input  SC_RegGENERAL_dir_InBUS,
        input  SC_RegGENERAL_sat_InHigh,
        output SC_RegGENERAL_data_OutBUS,
        output SC_RegGENERAL_tc_OutBUS
    );

endinterface

// File: rtl/sc_regcounter_channel.sv
// rtl/sc_regcounter_channel.sv - one loadable up/down wrap/saturate counter with registered terminal count
module sc_regcounter_channel
    import sc_regcounter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int MAX_COUNT = 2**DATAWIDTH - 1
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [DATAWIDTH-1:0] load_val_i,
    input  logic                 step_i,
    input  logic                 dir_i,
    input  logic                 sat_i,
    output logic [DATAWIDTH-1:0] count_o,
    output logic                 tc_o
);

    localparam logic [DATAWIDTH-1:0] MAX_V   = MAX_COUNT[DATAWIDTH-1:0];
    localparam logic [DATAWIDTH:0]   MAX_EXT = {1'b0, MAX_V};

    logic [DATAWIDTH-1:0] count_q, count_d;
    logic                 tc_q, tc_d;
    logic [DATAWIDTH:0]   inc_w, dec_w;
    logic                 up_bound, dn_bound;

    // One extra bit: increment past MAX_COUNT and borrow below zero are both visible as bounds.
    assign inc_w    = {1'b0, count_q} + 1'b1;
    assign dec_w    = {1'b0, count_q} - 1'b1;
    assign up_bound = (inc_w > MAX_EXT);
    assign dn_bound = dec_w[DATAWIDTH];

    // Next state: clear > load > step > hold; tc only set by a step attempted at the bound.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (step_i) begin
            if (dir_i == DIR_UP) begin
                if (up_bound) begin
                    tc_d    = 1'b1;
                    count_d = (sat_i == MODE_SAT) ? MAX_V : '0;
                end else begin
                    count_d = inc_w[DATAWIDTH-1:0];
                end
            end else begin
                if (dn_bound) begin
                    tc_d    = 1'b1;
                    count_d = (sat_i == MODE_SAT) ? '0 : MAX_V;
                end else begin
                    count_d = dec_w[DATAWIDTH-1:0];
                end
            end
        end
    end

    // Count and tc registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/sc_regcounter_multich.sv
// rtl/sc_regcounter_multich.sv - multi-channel counter bank top; optional shared prescaler via SC_REGCOUNTER_PRESCALER_EN
module sc_regcounter_multich
    import sc_regcounter_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int CHANNELS     = 2,
    parameter int MAX_COUNT    = 2**DATAWIDTH - 1,
    parameter int PRESCALE_DIV = 50000000
)(
    input logic                  SC_RegGENERAL_CLOCK_50,
    input logic                  SC_RegGENERAL_RESET_InHigh,
    sc_regcounter_multich_if.slave bus
);

    localparam int                   SELW  = sel_width(CHANNELS);
    localparam logic [DATAWIDTH-1:0] MAX_V = MAX_COUNT[DATAWIDTH-1:0];

    logic [DATAWIDTH-1:0]          load_val;
    logic                          tick;
    logic [CHANNELS*DATAWIDTH-1:0] data_w;
    logic [CHANNELS-1:0]           tc_w;

    // Out-of-range load values saturate to the channel maximum.
    always_comb begin
        load_val = bus.SC_RegGENERAL_loadData_InBUS;
        if (bus.SC_RegGENERAL_loadData_InBUS > MAX_V) begin
            load_val = MAX_V;
        end
    end

`ifdef SC_REGCOUNTER_PRESCALER_EN
    localparam int              DIVW     = clog2(PRESCALE_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PRESCALE_DIV - 1);

    logic [DIVW-1:0] div_q, div_d;

    // Shared divider: ticks on its last value, restarted by clear.
    always_comb begin
        div_d = div_q + 1'b1;
        if (bus.SC_RegGENERAL_clear_InHigh || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic load_hit;

        // A select value with no matching channel loads nothing.
        assign load_hit = bus.SC_RegGENERAL_load_InHigh &&
                          (bus.SC_RegGENERAL_chSel_InBUS == SELW'(i));

        sc_regcounter_channel #(
            .DATAWIDTH (DATAWIDTH),
            .MAX_COUNT (MAX_COUNT)
        ) u_ch (
            .clk_i      (SC_RegGENERAL_CLOCK_50),
            .rst_i      (SC_RegGENERAL_RESET_InHigh),
            .clear_i    (bus.SC_RegGENERAL_clear_InHigh),
            .load_i     (load_hit),
            .load_val_i (load_val),
            .step_i     (bus.SC_RegGENERAL_en_InBUS[i] & tick),
            .dir_i      (bus.SC_RegGENERAL_dir_InBUS[i]),
            .sat_i      (bus.SC_RegGENERAL_sat_InHigh),
            .count_o    (data_w[i*DATAWIDTH +: DATAWIDTH]),
            .tc_o       (tc_w[i])
        );
    end

    assign bus.SC_RegGENERAL_data_OutBUS = data_w;
    assign bus.SC_RegGENERAL_tc_OutBUS   = tc_w;

endmodule
